// File: rtl/priority_arbiter8.sv
// ============================================================================
// Module   : priority_arbiter8
// Brief    : 8-requester grant/hold arbiter, fixed or round-robin, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_arbiter8 #(
   parameter int ROUND_ROBIN = 1,
   parameter int MAX_HOLD    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       none_on
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] C_MAX_HOLD   = 8'(MAX_HOLD);
   localparam bit         C_TIMEOUT_EN = (MAX_HOLD != 0);

   state_t     r_state;
   logic [7:0] r_hold_cnt;
   logic [2:0] r_last_ptr;
   logic [2:0] w_winner;
   logic       w_any;
   logic       w_release;

   assign w_any     = |req;
   assign w_release = !req[gnt_idx] || (C_TIMEOUT_EN && (r_hold_cnt == C_MAX_HOLD));

   // Later loop iterations overwrite earlier ones, so the last match is the
   // highest-priority candidate; for round-robin that is last_ptr-1.
   always_comb begin
      w_winner = 3'd0;
      if (ROUND_ROBIN != 0) begin
         for (int k = 8; k >= 1; k--) begin
            if (req[r_last_ptr - 3'(k)]) begin
               w_winner = r_last_ptr - 3'(k);
            end
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (req[k]) begin
               w_winner = 3'(k);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_hold_cnt <= 8'd0;
         r_last_ptr <= 3'd0;
         gnt        <= 8'h00;
         gnt_idx    <= 3'd0;
         none_on    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE, S_GAP: begin
               if (w_any) begin
                  r_state    <= S_GRANT;
                  gnt        <= 8'h01 << w_winner;
                  gnt_idx    <= w_winner;
                  r_last_ptr <= w_winner;
                  r_hold_cnt <= 8'd1;
                  none_on    <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  gnt     <= 8'h00;
                  none_on <= 1'b1;
               end
            end
            S_GRANT: begin
               if (w_release) begin
                  r_state <= S_GAP;
                  gnt     <= 8'h00;
                  none_on <= 1'b1;
               end else if (r_hold_cnt != 8'hFF) begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               gnt     <= 8'h00;
               none_on <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_priority_arbiter8.sv
// ============================================================================
// Module   : tb_priority_arbiter8
// Brief    : Directed scoreboard bench for three priority_arbiter8 configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_arbiter8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_a = 8'h00, req_b = 8'h00, req_c = 8'h00;
   logic [7:0] gnt_a, gnt_b, gnt_c;
   logic [2:0] idx_a, idx_b, idx_c;
   logic       none_a, none_b, none_c;

   int n_pass  = 0;
   int n_total = 0;
   int sel     = 0;

   typedef struct {
      string      tag;
      logic [7:0] g;
      logic [2:0] i;
      logic       n;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // A: round-robin, 4-cycle timeout; B: fixed, 4-cycle timeout; C: fixed, no timeout
   priority_arbiter8 #(.ROUND_ROBIN(1), .MAX_HOLD(4)) u_dut_a (
      .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a), .none_on(none_a));
   priority_arbiter8 #(.ROUND_ROBIN(0), .MAX_HOLD(4)) u_dut_b (
      .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b), .none_on(none_b));
   priority_arbiter8 #(.ROUND_ROBIN(0), .MAX_HOLD(0)) u_dut_c (
      .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c), .none_on(none_c));

   task automatic push(input string tag, input logic [7:0] g, input logic [2:0] i);
      exp_t e;
      e.tag = tag;
      e.g   = g;
      e.i   = i;
      e.n   = (g == 8'h00);
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t       e;
      logic [7:0] og;
      logic [2:0] oi;
      logic       on;
      e = sb.pop_front();
      case (sel)
         0:       begin og = gnt_a; oi = idx_a; on = none_a; end
         1:       begin og = gnt_b; oi = idx_b; on = none_b; end
         default: begin og = gnt_c; oi = idx_c; on = none_c; end
      endcase
      n_total++;
      assert (og === e.g) n_pass++;
      else $error("FAIL %s gnt got %h expected %h", e.tag, og, e.g);
      n_total++;
      assert (oi === e.i) n_pass++;
      else $error("FAIL %s gnt_idx got %0d expected %0d", e.tag, oi, e.i);
      n_total++;
      assert (on === e.n) n_pass++;
      else $error("FAIL %s none_on got %b expected %b", e.tag, on, e.n);
   endtask

   task automatic tick(input string tag, input logic [7:0] g, input logic [2:0] i);
      push(tag, g, i);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   initial begin
      int w;

      // Reset state
      #12;
      for (int d = 0; d < 3; d++) begin
         sel = d;
         push("reset", 8'h00, 3'd0);
         pop_check();
      end
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         sel = c % 3;
         tick("idle_after_reset", 8'h00, 3'd0);
      end

      // Fixed priority, voluntary release then next-highest
      sel   = 2;
      req_c = 8'hA4;
      tick("fixed_first", 8'h80, 3'd7);
      req_c = 8'h24;
      tick("fixed_gap", 8'h00, 3'd7);
      tick("fixed_second", 8'h20, 3'd5);
      req_c = 8'h00;
      tick("fixed_release_gap", 8'h00, 3'd5);
      tick("fixed_idle", 8'h00, 3'd5);

      // No preemption and unlimited hold well past counter saturation
      req_c = 8'h08;
      tick("hold_start", 8'h08, 3'd3);
      req_c = 8'h48;
      for (int c = 0; c < 300; c++) tick("hold_no_preempt", 8'h08, 3'd3);
      req_c = 8'h40;
      tick("hold_release_gap", 8'h00, 3'd3);
      tick("hold_next", 8'h40, 3'd6);
      req_c = 8'h00;
      tick("hold_end_gap", 8'h00, 3'd6);
      tick("hold_end_idle", 8'h00, 3'd6);

      // Round-robin with timeout: 7,6,...,0,7 each for 4 cycles with 1-cycle gaps
      sel   = 0;
      req_a = 8'hFF;
      for (int n = 0; n < 9; n++) begin
         w = (n == 8) ? 7 : 7 - n;
         for (int c = 0; c < 4; c++) tick("rr_grant", 8'h01 << w, 3'(w));
         if (n == 8) req_a = 8'h00;
         tick("rr_gap", 8'h00, 3'(w));
      end
      tick("rr_idle", 8'h00, 3'd7);

      // Fixed priority with timeout: requester 7 keeps winning after each gap
      sel   = 1;
      req_b = 8'hFF;
      for (int n = 0; n < 3; n++) begin
         for (int c = 0; c < 4; c++) tick("fx_to_grant", 8'h80, 3'd7);
         if (n == 2) req_b = 8'h00;
         tick("fx_to_gap", 8'h00, 3'd7);
      end
      tick("fx_to_idle", 8'h00, 3'd7);

      // Asynchronous reset mid-grant, then a fresh grant after release
      req_b = 8'h10;
      tick("pre_rst_grant", 8'h10, 3'd4);
      tick("pre_rst_hold", 8'h10, 3'd4);
      #2;
      rst = 1'b1;
      push("async_rst", 8'h00, 3'd0);
      #1;
      pop_check();
      req_b = 8'h01;
      #2;
      rst = 1'b0;
      tick("post_rst_grant", 8'h01, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
